// File: rtl/acc_pkg.sv
// Shared definitions for the acc_core / acc_ctrl pair: default widths and
// the sequencer state encoding.
package acc_pkg;

    localparam int DEF_IN_DATA_WIDTH = 8;
    localparam int DEF_DWIDTH        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_ctrl_fsm.sv
// Sequencer state register for acc_ctrl. The qualified job events are
// computed in the parent; this block only decides where to go next.
module acc_ctrl_fsm
    import acc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start_job_i,
    input  logic   start_zero_i,
    input  logic   last_issue_i,
    input  logic   last_ack_i,
    output state_e state_o
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_job_i) begin
                    state_d = ST_RUN;
                end else if (start_zero_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_issue_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/acc_ctrl.sv
// Job sequencer for acc_core: streams N operands from a 1-cycle-latency
// memory into the core and reports the job sum relative to the start total.
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int AWIDTH        = 6,
    parameter int CNT_WIDTH     = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [CNT_WIDTH-1:0]     num_cnt_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    output logic                     idle_o,
    output logic                     running_o,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        result_o,
    output logic                     mem_ce_o,
    output logic [AWIDTH-1:0]        mem_addr_o,
    input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o,
    input  logic                     acc_valid_i,
    input  logic [DWIDTH-1:0]        acc_result_i
);

    state_e state;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0] ack_cnt_q, ack_cnt_d;
    logic [AWIDTH-1:0]    base_q, base_d;
    logic [DWIDTH-1:0]    baseline_q, baseline_d;
    logic [DWIDTH-1:0]    result_q, result_d;
    logic                 acc_valid_q, acc_valid_d;

    logic in_idle, in_run, in_drain;
    logic start_job, start_zero, last_issue, last_ack;

    assign in_idle  = (state == ST_IDLE);
    assign in_run   = (state == ST_RUN);
    assign in_drain = (state == ST_DRAIN);

    assign start_job  = in_idle && start_i && (num_cnt_i != '0);
    assign start_zero = in_idle && start_i && (num_cnt_i == '0);
    assign last_issue = in_run && (issue_cnt_q == cnt_q - CNT_WIDTH'(1));
    // The core reports its updated total in the same cycle as the final ack.
    assign last_ack   = (in_run || in_drain) && acc_valid_i &&
                        (ack_cnt_q + CNT_WIDTH'(1) == cnt_q);

    acc_ctrl_fsm u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_job_i  (start_job),
        .start_zero_i (start_zero),
        .last_issue_i (last_issue),
        .last_ack_i   (last_ack),
        .state_o      (state)
    );

    always_comb begin
        cnt_d       = cnt_q;
        issue_cnt_d = issue_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        base_d      = base_q;
        baseline_d  = baseline_q;
        result_d    = result_q;
        acc_valid_d = in_run;

        if (start_job) begin
            cnt_d       = num_cnt_i;
            base_d      = base_addr_i;
            baseline_d  = acc_result_i;
            issue_cnt_d = '0;
            ack_cnt_d   = '0;
        end else if (start_zero) begin
            result_d = '0;
        end

        if (in_run) begin
            issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
        end

        if ((in_run || in_drain) && acc_valid_i) begin
            ack_cnt_d = ack_cnt_q + CNT_WIDTH'(1);
        end

        // Modular difference stays correct across core total wrap-around.
        if (last_ack) begin
            result_d = acc_result_i - baseline_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            issue_cnt_q <= '0;
            ack_cnt_q   <= '0;
            base_q      <= '0;
            baseline_q  <= '0;
            result_q    <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            issue_cnt_q <= issue_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            base_q      <= base_d;
            baseline_q  <= baseline_d;
            result_q    <= result_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign idle_o       = in_idle;
    assign running_o    = in_run || in_drain;
    assign done_o       = (state == ST_DONE);
    assign result_o     = result_q;
    assign mem_ce_o     = in_run;
    assign mem_addr_o   = in_run ? (base_q + AWIDTH'(issue_cnt_q)) : '0;
    assign acc_run_o    = in_run || in_drain;
    assign acc_valid_o  = acc_valid_q;
    assign acc_number_o = acc_valid_q ? mem_q_i : '0;

endmodule
